// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction/PC buffer between fetch and decode, flushable on redirect.
module fetch_queue #(
  parameter int IWIDTH = 24,
  parameter int PWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       f_valid_i,
  input  logic [IWIDTH-1:0]          f_instr_i,
  input  logic [PWIDTH-1:0]          f_pc_i,
  output logic                       f_ready_o,
  output logic                       d_valid_o,
  output logic [IWIDTH-1:0]          d_instr_o,
  output logic [PWIDTH-1:0]          d_pc_o,
  input  logic                       d_ready_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [IWIDTH-1:0] instr_mem [DEPTH];
  logic [PWIDTH-1:0] pc_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign f_ready_o = count != CW'(DEPTH);
  assign d_valid_o = count != '0;
  assign push = f_valid_i & f_ready_o & ~flush_i;
  assign pop = d_valid_o & d_ready_i & ~flush_i;
  assign d_instr_o = d_valid_o ? instr_mem[rd_ptr] : '0;
  assign d_pc_o = d_valid_o ? pc_mem[rd_ptr] : '0;
  assign count_o = count;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      instr_mem[wr_ptr] <= f_instr_i;
      pc_mem[wr_ptr] <= f_pc_i;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus randomized checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
  localparam int IW = 24, PW = 16, D = 4;
  logic clk = 0, rst, fv, dr, fl, fr, dv;
  logic [IW-1:0] fi, di;
  logic [PW-1:0] fp, dp;
  logic [2:0] cnt;
  int passed = 0, total = 0;
  logic en = 0;
  typedef struct packed { logic [IW-1:0] i; logic [PW-1:0] p; } ent_t;
  ent_t q[$];

  fetch_queue #(.IWIDTH(IW), .PWIDTH(PW), .DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .f_valid_i(fv), .f_instr_i(fi), .f_pc_i(fp),
    .f_ready_o(fr), .d_valid_o(dv), .d_instr_o(di), .d_pc_o(dp),
    .d_ready_i(dr), .flush_i(fl), .count_o(cnt));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      en <= 1;
    end else if (fl) q.delete();
    else begin
      bit do_push, do_pop;
      do_push = fv && q.size() < D;
      do_pop = dr && q.size() > 0;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{fi, fp});
    end
  end

  always @(negedge clk) if (en) begin
    check("m_count", 32'(cnt), 32'(q.size()));
    check("m_valid", 32'(dv), 32'(q.size() != 0));
    check("m_ready", 32'(fr), 32'(q.size() != D));
    check("m_instr", 32'(di), q.size() ? 32'(q[0].i) : 0);
    check("m_pc", 32'(dp), q.size() ? 32'(q[0].p) : 0);
  end

  task automatic cyc(input logic v, input logic [IW-1:0] i, input logic [PW-1:0] p,
                     input logic r, input logic f, input logic s);
    fv = v; fi = i; fp = p; dr = r; fl = f; rst = s;
    @(posedge clk); #1;
  endtask

  initial begin
    fv = 0; fi = 'x; fp = 'x; dr = 0; fl = 0; rst = 1;
    cyc(0, 'x, 'x, 0, 0, 1);
    cyc(0, 'x, 'x, 0, 0, 1);
    cyc(0, 'x, 'x, 0, 0, 0);
    check("rst_valid", 32'(dv), 0);
    check("rst_ready", 32'(fr), 1);
    check("rst_count", 32'(cnt), 0);
    check("rst_instr", 32'(di), 0);
    check("rst_pc", 32'(dp), 0);
    cyc(1, 24'hA00001, 16'h0004, 0, 0, 0);
    check("one_valid", 32'(dv), 1);
    check("one_instr", 32'(di), 32'hA00001);
    check("one_pc", 32'(dp), 32'h0004);
    check("one_count", 32'(cnt), 1);
    cyc(0, 'x, 'x, 1, 0, 0);
    for (int k = 1; k <= 4; k++) cyc(1, IW'(k), PW'(4 * k), 0, 0, 0);
    check("full_count", 32'(cnt), 4);
    check("full_ready", 32'(fr), 0);
    cyc(1, 24'h000005, 16'h0014, 0, 0, 0);
    check("drop_count", 32'(cnt), 4);
    for (int k = 1; k <= 4; k++) begin
      check("drain_instr", 32'(di), 32'(k));
      check("drain_pc", 32'(dp), 32'(4 * k));
      cyc(0, 'x, 'x, 1, 0, 0);
    end
    check("drain_count", 32'(cnt), 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1, IW'(24'h100 + k), PW'(k), 1, 0, 0);
      check("stream_count", 32'(cnt), 1);
      check("stream_instr", 32'(di), 32'(24'h100 + k));
    end
    cyc(0, 'x, 'x, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, IW'(k), PW'(k), 0, 0, 0);
    check("pre_flush_count", 32'(cnt), 3);
    cyc(1, 24'hBBBBBB, 16'h0BBB, 1, 1, 0);
    check("flush_count", 32'(cnt), 0);
    check("flush_valid", 32'(dv), 0);
    cyc(1, 24'hCCCCCC, 16'h0CCC, 0, 0, 0);
    check("post_flush_head", 32'(di), 32'hCCCCCC);
    cyc(1, 24'h000777, 16'h0777, 0, 0, 0);
    check("pre_rst_count", 32'(cnt), 2);
    cyc(1, 24'h000888, 16'h0888, 1, 0, 1);
    check("mid_rst_count", 32'(cnt), 0);
    check("mid_rst_valid", 32'(dv), 0);
    check("mid_rst_ready", 32'(fr), 1);
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 9) < 7, IW'($urandom), PW'($urandom),
          $urandom_range(0, 9) < 5, $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
    cyc(0, 'x, 'x, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
